// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator: correlates received BPSK samples against a reference sine,
// decides one bit per symbol and packs the bits MSB first into data words.
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12
) (
  input  logic                             clk,
  input  logic                             arstn,
  input  logic                             en,
  input  logic signed [SAMPLE_WIDTH-1:0]   signal_in,
  input  logic signed [SAMPLE_WIDTH-1:0]   sin_in,
  output logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_out,
  output logic                             bit_out,
  output logic                             bit_valid,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid
);
  localparam int CW = $clog2(SAMPLE_NUMBER);
  localparam int PW = 2 * SAMPLE_WIDTH;
  localparam int AW = PW + CW;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  logic signed [PW-1:0] product;
  logic signed [AW-1:0] acc, sum;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shift, word;
  logic last, dec;
  always_comb begin
    product = PW'(signal_in) * PW'(sin_in);
    // sample 0 starts a fresh correlation, dropping the previous symbol
    sum = (cnt_out == '0 ? '0 : acc) + AW'(product);
    last = cnt_out == CW'(SAMPLE_NUMBER - 1);
    dec = ~sum[AW-1];
    word = (shift << 1) | DATA_WIDTH'(dec);
  end
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_out    <= '0;
      acc        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      data_valid <= 1'b0;
      if (en) begin
        cnt_out <= cnt_out + 1'b1;
        acc     <= sum;
        if (last) begin
          bit_out   <= dec;
          bit_valid <= 1'b1;
          shift     <= word;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            bit_cnt    <= '0;
            data_out   <= word;
            data_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bpsk_demodulator.sv
// tb_bpsk_demodulator: randomized self-checking bench; the reference model
// correlates each symbol with plain arithmetic and packs decided bits into words.
module tb_bpsk_demodulator;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic en = 1'b0;
  logic signed [11:0] signal_in = '0;
  logic signed [11:0] sin_in;
  logic [7:0] cnt_out;
  logic bit_out, bit_valid, data_valid;
  logic [11:0] data_out;
  logic signed [11:0] rom [256];
  logic fs = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int mcnt = 0, mbits = 0;
  longint msum = 0;
  logic [11:0] mword = '0, exp_data = '0;
  logic exp_bit = 1'b0;
  bpsk_demodulator dut (
    .clk(clk), .arstn(arstn), .en(en), .signal_in(signal_in), .sin_in(sin_in),
    .cnt_out(cnt_out), .bit_out(bit_out), .bit_valid(bit_valid),
    .data_out(data_out), .data_valid(data_valid)
  );
  always #5 clk = ~clk;
  assign sin_in = fs ? 12'h800 : rom[cnt_out];
  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int refs(input int k);
    return fs ? -2048 : int'(rom[k]);
  endfunction
  task automatic model_reset();
    mcnt = 0; msum = 0; mbits = 0; mword = '0; exp_bit = 1'b0; exp_data = '0;
  endtask
  // one clock: apply inputs, advance the model, check every output after the edge
  task automatic drive(input bit e, input int s);
    bit ev = 1'b0, dv = 1'b0;
    en = e;
    signal_in = 12'(s);
    if (e) begin
      msum = (mcnt == 0 ? 0 : msum) + longint'(s) * longint'(refs(mcnt));
      if (mcnt == 255) begin
        exp_bit = msum >= 0;
        ev = 1'b1;
        mword = {mword[10:0], exp_bit};
        if (++mbits == 12) begin
          exp_data = mword;
          dv = 1'b1;
          mbits = 0;
        end
        mcnt = 0;
      end else mcnt++;
    end
    @(posedge clk);
    #1;
    check("cnt_out", cnt_out, mcnt);
    check("bit_valid", bit_valid, ev);
    check("bit_out", bit_out, exp_bit);
    check("data_valid", data_valid, dv);
    check("data_out", data_out, exp_data);
  endtask
  function automatic int clip(input int v);
    return v > 2047 ? 2047 : v < -2048 ? -2048 : v;
  endfunction
  // mode 0 clean, 1 silent, 2 noisy, 3 full-scale negative on both inputs
  task automatic send_word(input logic [11:0] d, input int mode, input bit gaps,
                           input int stop_bit, input int stop_k);
    fs = mode == 3;
    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < 256; k++) begin
        int s;
        if (b == stop_bit && k == stop_k) return;
        if (gaps && (k == 0 || k == 255 || $urandom_range(15) == 0))
          repeat ($urandom_range(7, 1)) drive(1'b0, int'($urandom_range(4095)) - 2048);
        s = d[11-b] ? refs(k) : -refs(k);
        s = mode == 1 ? 0 : mode == 2 ? clip(s + int'($urandom_range(3000)) - 1500)
          : mode == 3 ? -2048 : s;
        drive(1'b1, s);
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 256; k++)
      rom[k] = 12'($rtoi($floor(2047.0 * $sin(2.0 * 3.14159265358979 * k / 256.0) + 0.5)));
    #2;
    check("rst_cnt", cnt_out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
    send_word(12'hA5C, 0, 1'b0, -1, -1);
    check("word_a5c", data_out, 12'hA5C);
    send_word(12'h123, 1, 1'b0, -1, -1);
    check("word_zero_sig", data_out, 12'hFFF);
    send_word(12'h000, 0, 1'b0, -1, -1);
    check("word_000", data_out, 12'h000);
    send_word(12'hFFF, 0, 1'b0, -1, -1);
    check("word_fff", data_out, 12'hFFF);
    send_word(12'h5A3, 0, 1'b1, -1, -1);
    check("word_5a3_gaps", data_out, 12'h5A3);
    send_word(12'h0F0, 0, 1'b0, 5, 100);
    #2 arstn = 1'b0;
    #1;
    check("arst_cnt", cnt_out, 0);
    check("arst_bit_out", bit_out, 0);
    check("arst_bit_valid", bit_valid, 0);
    check("arst_data_out", data_out, 0);
    check("arst_data_valid", data_valid, 0);
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_cnt", cnt_out, 0);
    check("arst_hold_bv", bit_valid, 0);
    arstn = 1'b1;
    en = 1'b0;
    model_reset();
    send_word(12'h3C9, 0, 1'b0, -1, -1);
    check("word_3c9", data_out, 12'h3C9);
    send_word(12'h000, 3, 1'b0, -1, -1);
    check("word_fullscale", data_out, 12'hFFF);
    fs = 1'b0;
    repeat (3) begin
      logic [11:0] d;
      d = 12'($urandom);
      send_word(d, 2, 1'b1, -1, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
